// File: rtl/ppu_vram_pkg.sv
// Shared types and constants for the PPU video-memory responder.
package ppu_vram_pkg;

  typedef enum logic [1:0] {
    MIR_HORIZ    = 2'b00,
    MIR_VERT     = 2'b01,
    MIR_SINGLE_A = 2'b10,
    MIR_SINGLE_B = 2'b11
  } mirror_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REG_CHR = 2'b00,
    REG_NT  = 2'b01,
    REG_PAL = 2'b10
  } region_e;

  localparam logic [13:0] CHR_BASE = 14'h0000;
  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

  localparam int CIRAM_DEPTH = 2048;
  localparam int PAL_DEPTH   = 32;

endpackage

// File: rtl/ppu_vram_responder_if.sv
// PPU video bus plus CHR loader stream; the responder uses the slave modport.
interface ppu_vram_responder_if;
  logic [13:0] ppu2vram_addr;
  logic [7:0]  ppu2vram_data;
  logic        ppu2vram_wr;
  logic [7:0]  vram2ppu_data;
  logic        chr_load_valid;
  logic [12:0] chr_load_addr;
  logic [7:0]  chr_load_data;
  logic        chr_load_ready;

  modport master (
    output ppu2vram_addr, ppu2vram_data, ppu2vram_wr,
    output chr_load_valid, chr_load_addr, chr_load_data,
    input  vram2ppu_data, chr_load_ready
  );

  modport slave (
    input  ppu2vram_addr, ppu2vram_data, ppu2vram_wr,
    input  chr_load_valid, chr_load_addr, chr_load_data,
    output vram2ppu_data, chr_load_ready
  );
endinterface

// File: rtl/ppu_vram_addr_map.sv
// Combinational PPU address decoder: region select plus local index per region.
// PPU_VRAM_PAL_MIRROR_EN folds palette entries 0x10/0x14/0x18/0x1C onto 0x00/0x04/0x08/0x0C.
module ppu_vram_addr_map
  import ppu_vram_pkg::*;
(
  input  logic [13:0] addr,
  input  mirror_e     mode,
  output region_e     region,
  output logic [12:0] chr_idx,
  output logic [10:0] nt_idx,
  output logic [4:0]  pal_idx
);

  logic page_s;

  // Region, nametable page and palette index decode
  always_comb begin
    region  = REG_CHR;
    chr_idx = addr[12:0];
    page_s  = 1'b0;
    pal_idx = addr[4:0];
    if (addr < NT_BASE) begin
      region = REG_CHR;
    end else if (addr < PAL_BASE) begin
      region = REG_NT;
    end else begin
      region = REG_PAL;
    end
    case (mode)
      MIR_HORIZ:    page_s = addr[11];
      MIR_VERT:     page_s = addr[10];
      MIR_SINGLE_A: page_s = 1'b0;
      MIR_SINGLE_B: page_s = 1'b1;
      default:      page_s = 1'b0;
    endcase
    nt_idx = {page_s, addr[9:0]};
`ifdef PPU_VRAM_PAL_MIRROR_EN
    if (addr[4] && (addr[1:0] == 2'b00)) begin
      pal_idx = {1'b0, addr[3:0]};
    end else begin
      pal_idx = addr[4:0];
    end
`else
    pal_idx = addr[4:0];
`endif
  end

endmodule

// File: rtl/ppu_vram_responder.sv
// PPU-side VRAM responder: CHR, mirrored CIRAM and palette with 1-cycle registered reads.
// Palette aliasing is enabled by defining PPU_VRAM_PAL_MIRROR_EN.
module ppu_vram_responder
  import ppu_vram_pkg::*;
#(
  parameter bit CHR_IS_RAM = 1'b1,
  parameter int CIRAM_AW   = 11,
  parameter int CHR_AW     = 13
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mirror_mode,
  output logic                 init_done,
  ppu_vram_responder_if.slave  bus
);

  logic [7:0]          chr_mem   [0:(1<<CHR_AW)-1];
  logic [7:0]          ciram_mem [0:(1<<CIRAM_AW)-1];
  logic [5:0]          pal_mem   [0:PAL_DEPTH-1];

  state_e              state_r, state_next_s;
  logic [CIRAM_AW-1:0] cnt_r;
  logic                init_done_r;
  logic [7:0]          rdata_r;

  region_e             region_s;
  logic [12:0]         chr_idx_s;
  logic [10:0]         nt_idx_s;
  logic [4:0]          pal_idx_s;

  logic                run_s, clear_s, ppu_wr_s, load_ready_s;
  logic                chr_we_s, ciram_we_s, pal_we_s;
  logic [12:0]         chr_wa_s;
  logic [7:0]          chr_wd_s, ciram_wd_s;
  logic [CIRAM_AW-1:0] ciram_wa_s;
  logic [4:0]          pal_wa_s;
  logic [5:0]          pal_wd_s;

  ppu_vram_addr_map u_addr_map (
    .addr    (bus.ppu2vram_addr),
    .mode    (mirror_e'(mirror_mode)),
    .region  (region_s),
    .chr_idx (chr_idx_s),
    .nt_idx  (nt_idx_s),
    .pal_idx (pal_idx_s)
  );

  // State, clear counter and init flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= {CIRAM_AW{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == ST_RUN);
      if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + CIRAM_AW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next state: leave CLEAR after the last CIRAM entry
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == {CIRAM_AW{1'b1}}) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_CLEAR;
    endcase
  end

  // Write-port steering; the PPU owns the CHR port when it writes below NT_BASE
  always_comb begin
    run_s        = (state_r == ST_RUN) && !reset;
    clear_s      = (state_r == ST_CLEAR) && !reset;
    ppu_wr_s     = run_s && bus.ppu2vram_wr;
    load_ready_s = run_s && !(bus.ppu2vram_wr && (region_s == REG_CHR));

    chr_we_s = 1'b0;
    chr_wa_s = bus.chr_load_addr;
    chr_wd_s = bus.chr_load_data;
    if (ppu_wr_s && (region_s == REG_CHR)) begin
      chr_we_s = CHR_IS_RAM;
      chr_wa_s = chr_idx_s;
      chr_wd_s = bus.ppu2vram_data;
    end else begin
      chr_we_s = load_ready_s && bus.chr_load_valid;
    end

    if (clear_s) begin
      ciram_we_s = 1'b1;
      ciram_wa_s = cnt_r;
      ciram_wd_s = 8'h00;
      pal_we_s   = (cnt_r < CIRAM_AW'(PAL_DEPTH));
      pal_wa_s   = cnt_r[4:0];
      pal_wd_s   = 6'h00;
    end else begin
      ciram_we_s = ppu_wr_s && (region_s == REG_NT);
      ciram_wa_s = nt_idx_s;
      ciram_wd_s = bus.ppu2vram_data;
      pal_we_s   = ppu_wr_s && (region_s == REG_PAL);
      pal_wa_s   = pal_idx_s;
      pal_wd_s   = bus.ppu2vram_data[5:0];
    end
  end

  // Memory write ports
  always_ff @(posedge clock) begin
    if (chr_we_s) begin
      chr_mem[chr_wa_s] <= chr_wd_s;
    end
    if (ciram_we_s) begin
      ciram_mem[ciram_wa_s] <= ciram_wd_s;
    end
    if (pal_we_s) begin
      pal_mem[pal_wa_s] <= pal_wd_s;
    end
  end

  // Registered read; sees pre-write contents on a same-cycle write
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_r <= 8'h00;
    end else if (state_r != ST_RUN) begin
      rdata_r <= 8'h00;
    end else begin
      case (region_s)
        REG_CHR: rdata_r <= chr_mem[chr_idx_s];
        REG_NT:  rdata_r <= ciram_mem[nt_idx_s];
        REG_PAL: rdata_r <= {2'b00, pal_mem[pal_idx_s]};
        default: rdata_r <= 8'h00;
      endcase
    end
  end

  assign bus.vram2ppu_data  = rdata_r;
  assign bus.chr_load_ready = load_ready_s;
  assign init_done          = init_done_r;

endmodule

// File: doc/ppu_vram_responder.md
Name: ppu_vram_responder

Overview:
- Responder side of the PPU video-memory bus: answers every `ppu2vram_addr` with `vram2ppu_data` one clock later.
- Decodes the 14-bit PPU address space into three regions:
  - CHR pattern memory (8 KB).
  - CIRAM nametable memory (2 KB) with selectable mirroring.
  - Palette RAM (32 x 6 bits).
- Accepts PPU writes (the $2007 path) and a CHR loader stream from the cartridge/boot side.
- On reset, clears CIRAM and palette with an internal sequencer before it serves requests.

Parameters:
- CHR_IS_RAM, 1, 1 = CHR region writable via `ppu2vram_wr`; 0 = CHR writable only through the loader port.
- CIRAM_AW, 11, CIRAM address width (2048 bytes).
- CHR_AW, 13, CHR address width (8192 bytes).

Ports:
- clock  in  1  system clock, PPU rate
- reset  in  1  synchronous, active-high
- ppu2vram_addr  in  14  PPU bus address, sampled every cycle
- ppu2vram_data  in  8  PPU write data
- ppu2vram_wr  in  1  write strobe, qualifies addr/data this cycle
- vram2ppu_data  out  8  read data for the address presented the previous cycle
- mirror_mode  in  2  00 horizontal, 01 vertical, 10 single-screen A, 11 single-screen B
- chr_load_valid  in  1  loader has a byte
- chr_load_addr  in  13  CHR byte address
- chr_load_data  in  8  CHR byte
- chr_load_ready  out  1  loader byte accepted when valid&ready
- init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset (synchronous, active-high):
  - State = CLEAR, clear counter = 0.
  - `vram2ppu_data`, `init_done` and `chr_load_ready` = 0.
  - CHR contents are not cleared.
- CLEAR state:
  - Each cycle writes 0x00 to CIRAM[cnt]; palette[cnt[4:0]] is also written while cnt < 32.
  - cnt increments each cycle. At cnt = 2047 the next state is RUN and `init_done` rises in the same edge.
  - Total duration is 2048 cycles.
  - PPU writes are ignored, `vram2ppu_data` = 0x00, `chr_load_ready` = 0.
- RUN state:
  - Stays in RUN until reset. Reset mid-operation (either state) restarts CLEAR from cnt = 0.
- Address decode, on `ppu2vram_addr` A:
  - A < 0x2000: CHR[A[12:0]].
  - 0x2000 ≤ A < 0x3F00: CIRAM[{page, A[9:0]}], with page selected by mode:
    - horizontal: page = A[11]
    - vertical: page = A[10]
    - single A: page = 0
    - single B: page = 1
  - A ≥ 0x3F00: palette[P], where P = A[4:0] (see optional feature).
    - Reads return {2'b00, pal[5:0]}.
    - Writes store data[5:0].
- Read latency:
  - Exactly 1 cycle: the data for A presented at edge n appears after edge n+1, registered. This matches the PPU fetch slots, which present an address and sample on the next counter step.
- Same-cycle read and write to the same location: read-before-write. The output shows the old value; the new value is visible from the next access.
- Write rules in RUN:
  - Requires `ppu2vram_wr` = 1.
  - CHR writes are dropped when CHR_IS_RAM = 0.
- Loader handshake:
  - `chr_load_ready` = 1 in RUN except in cycles where `ppu2vram_wr` = 1 and A < 0x2000. The PPU write wins and the loader stalls.
  - The transfer occurs on an edge with valid & ready.
  - The loader may change addr/data only after acceptance.
  - The loader is ignored in CLEAR.
- Width rules: address bits above 13 do not exist; A[13:12] = 11 with A[11:8] = 0xF selects palette. No wrap logic is needed beyond field truncation.

Optional Feature:
- Macro: PPU_VRAM_PAL_MIRROR_EN.
- With the macro defined: if A[4] = 1 and A[1:0] = 00, P = {1'b0, A[3:0]}. Entries 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C for both read and write.
- Without it: all 32 palette entries are distinct.

Decomposition:
- Package `ppu_vram_pkg` holds:
  - mirror-mode enum
  - state enum {CLEAR, RUN}
  - region base constants CHR_BASE = 0x0000, NT_BASE = 0x2000, PAL_BASE = 0x3F00
  - CIRAM_DEPTH = 2048, PAL_DEPTH = 32
- One sub-module, `ppu_vram_addr_map`:
  - Combinational decoder: A + mirror_mode → region select plus local index.
  - Reusable by the CPU-side $2007 model.

Test Plan:
- Reset, then count cycles → `init_done` low for exactly 2048 cycles. Reads of 0x2000, 0x27FF and 0x3F1F during and after CLEAR return 0x00.
- Vertical mode, write 0xAB to 0x2005; read 0x2805 → 0xAB one cycle after the address. Read 0x2405 → 0x00. Switch to horizontal; read 0x2405 → 0xAB.
- Loader writes 0x5A to CHR 0x1234 while the PPU simultaneously writes 0x77 to 0x0010 → `chr_load_ready` = 0 that cycle. The next cycle accepts. Reads give 0x1234 → 0x5A and 0x0010 → 0x77 (CHR_IS_RAM = 1), or 0x0010 → 0x00 (CHR_IS_RAM = 0).
- Write 0xFF to 0x3F10, read 0x3F10 → 0x3F. Read 0x3F00 → 0x3F with the macro defined, 0x00 without it.
- Write 0x11 to 0x2000 and read 0x2000 in the same cycle → 0x00 (old value); re-read → 0x11.
- Assert reset mid-RUN after data is written → CLEAR restarts, `init_done` drops, CIRAM reads 0x00 afterwards, CHR data is retained.
